// File: rtl/multi_sample_accumulator_if.sv
// Sample stream and result bundle for multi_sample_accumulator.
// master = sample source / result consumer side, slave = accumulator side.
interface multi_sample_accumulator_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] din;
    logic             irdy;
    logic [WIDTH-1:0] dout;
    logic             ordy;
    logic             ovf;
    logic             busy;

    modport master (
        output din,
        output irdy,
        input  dout,
        input  ordy,
        input  ovf,
        input  busy
    );

    modport slave (
        input  din,
        input  irdy,
        output dout,
        output ordy,
        output ovf,
        output busy
    );
endinterface

// File: rtl/multi_sample_accumulator.sv
// Sums COUNT consecutive WIDTH-bit unsigned samples per irdy request; result held until next start.
// Optional feature macro: MULTI_SAMPLE_ACCUMULATOR_SATURATE_EN (clamp dout to all-ones on carry-out).
module multi_sample_accumulator #(
    parameter int WIDTH = 16,
    parameter int COUNT = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    multi_sample_accumulator_if.slave   bus
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("multi_sample_accumulator: WIDTH must be in 2..32");
        end
        if (COUNT < 2 || COUNT > 256) begin : g_bad_count
            $error("multi_sample_accumulator: COUNT must be in 2..256");
        end
    endgenerate

    localparam int             CNT_W     = (COUNT > 2) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(COUNT - 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   dout_q,  dout_d;
    logic               ordy_q,  ordy_d;
    logic               ovf_q,   ovf_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   sum_lo;

    // Carry is kept as the extra top bit so overflow is observed at every step.
    assign sum = {1'b0, dout_q} + {1'b0, bus.din};

`ifdef MULTI_SAMPLE_ACCUMULATOR_SATURATE_EN
    // All-ones plus any further sample either carries again or stays all-ones,
    // so no separate "saturated" flag is needed to hold the clamp.
    assign sum_lo = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    assign sum_lo = sum[WIDTH-1:0];
`endif

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        state_d = state_q;
        dout_d  = dout_q;
        ordy_d  = ordy_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.irdy) begin
                    dout_d  = bus.din;
                    ordy_d  = 1'b0;
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_START;
                    state_d = ACCUM;
                end
            end

            ACCUM: begin
                dout_d = sum_lo;
                ovf_d  = ovf_q | sum[WIDTH];
                if (cnt_q == '0) begin
                    ordy_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            // Illegal encodings recover to IDLE without touching the outputs.
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q <= IDLE;
            dout_q  <= '0;
            ordy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            ordy_q  <= ordy_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.dout = dout_q;
    assign bus.ordy = ordy_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = (state_q == ACCUM);

endmodule
